pio_flag_sequencer: RTL
=======================

Name: pio_flag_sequencer

Overview:
- Avalon-MM master that owns the 8-bit bidirectional flag PIO. The PIO has data at address 0, direction at 1, bit-set at 4 and bit-clear at 5, with readdata registered one clock after address.
- Round-robin arbitrates two requesters (A = CPU bridge, B = display frame engine) for write/set/clear/direction operations.
- Every operation is a write, a settle delay, then a read-back verify with bounded retry. Results are reported by a one-cycle acknowledge per requester.

Parameters:
- WIDTH, 8, flag port width (1..32).
- SETTLE, 2, idle cycles between write strobe and read-back address (0..15).
- MAX_RETRY, 3, re-issues after first failed verify before reporting error (0..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_a / req_b  in  1  request. Held high with op/data stable until matching ack.
- op_a / op_b  in  2  operation: 00 write data, 01 set bits, 10 clear bits, 11 write direction.
- data_a / data_b  in  WIDTH  value (op 00/11) or mask (op 01/10).
- ack_a / ack_b  out  1  one-cycle completion pulse.
- err  out  1  valid with ack: 1 = verify failed after retries.
- busy  out  1  FSM not in IDLE.
- err_count  out  8  saturating count of failed operations.
- avm_address  out  3  PIO address.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO write strobe, active low.
- avm_writedata  out  32  zero-extended write data.
- avm_readdata  in  32  PIO readdata, registered, reflects address of previous cycle.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; ack_a/ack_b/err/busy = 0; err_count = 0.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0.
  - Shadows dir_sh = 0, out_sh = 0, matching the PIO reset. Last-grant pointer = B.
  - Reset mid-operation abandons the operation with no ack. Requester must re-request.
- FSM states: IDLE, WRITE, SETTLE, RADDR, RCAP, RESP.
- IDLE:
  - If either req is high, grant it. If both are high, grant the requester not granted last.
  - On grant, latch id/op/data, compute expected value and compare mask, clear retry count, go to WRITE.
  - A requester whose ack pulses this cycle is ignored this cycle.
- Expected value and compare mask per op:
  - 00: exp = data; mask = dir_sh.
  - 01: exp = out_sh | data; mask = dir_sh.
  - 10: exp = out_sh & ~data; mask = dir_sh.
  - 11: exp = data; mask = all ones.
- WRITE (1 cycle):
  - chipselect = 1, write_n = 0.
  - Address 0/4/5/1 for op 00/01/10/11; writedata = zero-extended data.
  - Update out_sh (ops 00-10) or dir_sh (op 11) to exp.
  - Go to SETTLE if SETTLE > 0, else RADDR.
- SETTLE: chipselect = 0, write_n = 1. Counts SETTLE cycles, then RADDR.
- RADDR (1 cycle):
  - chipselect = 1, write_n = 1, address = 1 for op 11, else 0.
  - Never drive address 4/5 with write_n = 0 outside WRITE.
- RCAP:
  - Sample avm_readdata[WIDTH-1:0].
  - Pass if (rd & mask) == (exp & mask). Bits with dir_sh = 0 are don't-care, so all-input ports always pass ops 00-10.
  - Pass: go to RESP with err = 0.
  - Fail with retries < MAX_RETRY: increment retries, go to WRITE (same address/data).
  - Fail otherwise: go to RESP with err = 1 and err_count++ (saturate at 255).
- RESP: pulse the granted ack with err for exactly one cycle, update last-grant, go to IDLE.
- Latency: grant in cycle 0, ack in cycle 4+SETTLE with no retry. Each retry adds 3+SETTLE cycles.
- Outside WRITE/RADDR, chipselect = 0 and write_n = 1. avm_writedata[31:WIDTH] = 0 always.
- busy = 1 in every state except IDLE.

Test Plan:
- Reset, then A op 11 data 0xFF; readdata at addr 1 returns 0xFF -> one write at addr 1, ack_a in cycle 6 (SETTLE = 2), err = 0, dir_sh = 0xFF.
- After dir = 0xFF: A op 01 mask 0x0C, readback 0x0C -> write addr 4 data 0x0C, read addr 0, ack_a, err = 0. Then B op 10 mask 0x04, readback 0x08 -> write addr 5, ack_b, err = 0.
- req_a and req_b high in the same cycle after reset -> A served first, B granted in the IDLE cycle after ack_a, acks never overlap.
- dir = 0xFF, A op 00 data 0x55, readdata forced to 0x54 -> 4 writes at addr 0 (1 + MAX_RETRY), ack_a with err = 1, err_count = 1.
- dir = 0x0F, op 00 data 0xA5, readback 0x35 -> pass, since only the low nibble is compared (0x5 == 0x5).
- Reset asserted during SETTLE -> outputs at reset values immediately, no ack. A new request after release completes normally.

Source files
------------

// File: rtl/pio_flag_sequencer_if.sv
// Avalon-MM bus between the flag sequencer (master) and the 8-bit flag PIO (slave).
//
// Signals:
//   avm_address     3   PIO register address (0 data, 1 direction, 4 bit-set, 5 bit-clear)
//   avm_chipselect  1   PIO chipselect
//   avm_write_n     1   write strobe, active low
//   avm_writedata   32  write data, zero-extended by the master
//   avm_readdata    32  registered read data, reflects the address of the previous cycle
interface pio_flag_sequencer_if;

    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/pio_flag_sequencer.sv
// Flag PIO sequencer: owns the bidirectional flag PIO and serialises write/set/clear/direction
// operations from two requesters (A = CPU bridge, B = display frame engine) with round-robin
// arbitration. Each operation is a write, SETTLE idle cycles, then a read-back verify with up
// to MAX_RETRY re-issues before an error is reported.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   req_a/req_b           request, held with op/data stable until the matching ack
//   op_a/op_b             00 write data, 01 set bits, 10 clear bits, 11 write direction
//   data_a/data_b         value (op 00/11) or mask (op 01/10)
//   ack_a/ack_b           one-cycle completion pulse
//   err                   valid with ack: verify failed after all retries
//   busy                  sequencer not idle
//   err_count             saturating count of failed operations
//   avm                   Avalon-MM master port to the PIO
module pio_flag_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_a,
    input  logic [1:0]                  op_a,
    input  logic [WIDTH-1:0]            data_a,
    input  logic                        req_b,
    input  logic [1:0]                  op_b,
    input  logic [WIDTH-1:0]            data_b,
    output logic                        ack_a,
    output logic                        ack_b,
    output logic                        err,
    output logic                        busy,
    output logic [7:0]                  err_count,
    pio_flag_sequencer_if.master        avm
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StSettle,
        StRaddr,
        StRcap,
        StResp
    } state_e;

    state_e           state_q;
    logic             id_q;          // 0 = A, 1 = B
    logic             last_b_q;      // last grant went to B
    logic [1:0]       op_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] dir_sh_q;
    logic [WIDTH-1:0] out_sh_q;
    logic [2:0]       retry_q;
    logic [3:0]       settle_cnt_q;
    logic [2:0]       addr_q;
    logic             cs_q;
    logic             write_n_q;
    logic [31:0]      wdata_q;

    logic             req_a_live;
    logic             req_b_live;
    logic             grant_b;
    logic [1:0]       gnt_op;
    logic [WIDTH-1:0] gnt_data;
    logic [WIDTH-1:0] gnt_exp;
    logic [WIDTH-1:0] gnt_mask;
    logic             rd_pass;
    logic             unused_rd;

    function automatic logic [2:0] wr_addr(input logic [1:0] op);
        logic [2:0] a;
        unique case (op)
            2'b00:   a = 3'd0;
            2'b01:   a = 3'd4;
            2'b10:   a = 3'd5;
            default: a = 3'd1;
        endcase
        return a;
    endfunction

    // Arbitration and expected read-back value for the candidate grant.
    always_comb begin
        req_a_live = req_a & ~ack_a;
        req_b_live = req_b & ~ack_b;
        grant_b    = req_b_live & (~req_a_live | ~last_b_q);
        gnt_op     = grant_b ? op_b : op_a;
        gnt_data   = grant_b ? data_b : data_a;
        gnt_exp    = gnt_data;
        gnt_mask   = dir_sh_q;
        unique case (gnt_op)
            2'b00:   gnt_exp = gnt_data;
            2'b01:   gnt_exp = out_sh_q | gnt_data;
            2'b10:   gnt_exp = out_sh_q & ~gnt_data;
            default: begin
                gnt_exp  = gnt_data;
                gnt_mask = '1;
            end
        endcase
        // Input-direction bits are don't-care in the compare.
        rd_pass = ((avm.avm_readdata[WIDTH-1:0] ^ exp_q) & mask_q) == '0;
    end

    // Upper readdata bits carry no flag state.
    assign unused_rd = ^avm.avm_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            id_q         <= 1'b0;
            last_b_q     <= 1'b1;
            op_q         <= 2'b00;
            exp_q        <= '0;
            mask_q       <= '0;
            dir_sh_q     <= '0;
            out_sh_q     <= '0;
            retry_q      <= '0;
            settle_cnt_q <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            wdata_q      <= '0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            err_count    <= '0;
        end else begin
            // Strobes and pulses default to idle; entering WRITE/RADDR/RESP overrides them.
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            err       <= 1'b0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (req_a_live || req_b_live) begin
                        id_q      <= grant_b;
                        op_q      <= gnt_op;
                        exp_q     <= gnt_exp;
                        mask_q    <= gnt_mask;
                        retry_q   <= '0;
                        busy      <= 1'b1;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= wr_addr(gnt_op);
                        wdata_q   <= 32'(gnt_data);
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    if (op_q == 2'b11) begin
                        dir_sh_q <= exp_q;
                    end else begin
                        out_sh_q <= exp_q;
                    end
                    if (SETTLE != 0) begin
                        settle_cnt_q <= '0;
                        state_q      <= StSettle;
                    end else begin
                        cs_q    <= 1'b1;
                        addr_q  <= (op_q == 2'b11) ? 3'd1 : 3'd0;
                        state_q <= StRaddr;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == 4'(SETTLE - 1)) begin
                        cs_q    <= 1'b1;
                        addr_q  <= (op_q == 2'b11) ? 3'd1 : 3'd0;
                        state_q <= StRaddr;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                StRaddr: begin
                    state_q <= StRcap;
                end
                StRcap: begin
                    if (rd_pass) begin
                        ack_a   <= ~id_q;
                        ack_b   <= id_q;
                        state_q <= StResp;
                    end else if (retry_q < 3'(MAX_RETRY)) begin
                        // wdata_q still holds the original write data.
                        retry_q   <= retry_q + 3'd1;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= wr_addr(op_q);
                        state_q   <= StWrite;
                    end else begin
                        ack_a   <= ~id_q;
                        ack_b   <= id_q;
                        err     <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    last_b_q <= id_q;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write_n    = write_n_q;
    assign avm.avm_writedata  = wdata_q;

endmodule
